// File: rtl/sim_monitor.sv
// Bring-up harness: core reset sequencing, cycle budget, exit and console mailboxes.
// Optional trace/finish hooks enabled by defining SIM_MONITOR_TRACE_EN.
module sim_monitor #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int COUNT_WIDTH  = 32,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 16,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR    = 16'hFFFE,
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = 16'hFFFC,
  parameter int CON_DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   we,
  output logic                   cpu_rst,
  output logic [COUNT_WIDTH-1:0] cycle_count,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [DATA_WIDTH-1:0]  exit_code,
  output logic                   con_valid,
  output logic [7:0]             con_data,
  input  logic                   con_ready,
  output logic                   con_overflow
);

  localparam int PW = $clog2(CON_DEPTH);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rst_ok;
  logic [HW-1:0]   hold_q, hold_d;
  logic            exit_hit, to_hit, con_push;

  logic [7:0]      mem [CON_DEPTH];
  logic [PW-1:0]   wp_q, rp_q;
  logic [PW:0]     cnt_q;
  logic            empty, full, pop, push_ok, drop;

  // Release of rst is only seen by the FSM after two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_ok = sync_q[1];

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    exit_hit = 1'b0;
    to_hit   = 1'b0;
    con_push = 1'b0;
    case (state_q)
      S_RESET: begin
        if (rst_ok) begin
          if (hold_q == HW'(RESET_CYCLES - 1)) state_d = S_RUN;
          else hold_d = hold_q + HW'(1);
        end
      end
      S_RUN: begin
        exit_hit = we && (waddr == EXIT_ADDR);
        con_push = we && (waddr == CONSOLE_ADDR);
        to_hit   = !exit_hit &&
                   (cycle_count == COUNT_WIDTH'(MAX_CYCLES - 1));
        if (exit_hit || to_hit) state_d = S_DONE;
      end
      S_DONE: ;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RESET;
      hold_q      <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      if (state_q == S_RUN && cycle_count != '1)
        cycle_count <= cycle_count + COUNT_WIDTH'(1);
      if (exit_hit) begin
        exit_code <= wdata;
        pass      <= (wdata == '0);
      end
      if (to_hit) timeout <= 1'b1;
    end
  end

  assign done    = (state_q == S_DONE);
  assign cpu_rst = (state_q != S_RUN);

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (PW+1)'(CON_DEPTH));
  assign pop     = !empty && con_ready;
  // A full FIFO still takes a byte when a pop frees a slot this cycle.
  assign push_ok = con_push && (!full || pop);
  assign drop    = con_push && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp_q] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      con_overflow <= 1'b0;
    end else begin
      if (push_ok) wp_q <= wp_q + PW'(1);
      if (pop)     rp_q <= rp_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (drop) con_overflow <= 1'b1;
    end
  end

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : mem[rp_q];

`ifdef SIM_MONITOR_TRACE_EN
  logic trc_seen_q, trc_fin_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trc_seen_q <= 1'b0;
      trc_fin_q  <= 1'b0;
    end else begin
      if (pop) $write("%c", con_data);
      if (done && !trc_seen_q) begin
        $display("sim_monitor: cycles=%0d pass=%0b timeout=%0b exit_code=%0h",
                 cycle_count, pass, timeout, exit_code);
        trc_seen_q <= 1'b1;
        trc_fin_q  <= 1'b1;
      end
      if (trc_fin_q) $finish;
    end
  end
`endif

endmodule

// File: doc/sim_monitor.md
# sim_monitor

Parametrised simulation and bring-up harness controller that sits between the board/bench reset and the `cpu` core's data-memory write port. Sequences the core reset, counts run cycles and enforces a cycle-budget timeout. Decodes writes to an exit mailbox (pass/fail with exit code) and to a console mailbox (bytes buffered in a small FIFO and drained over a valid/ready stream). Replaces the hard-coded reset-count and finish-count logic of earlier benches with a reusable, mostly synthesizable block.

## Interface

Parameters:

- `ADDR_WIDTH`, 16, width of `waddr`
- `DATA_WIDTH`, 16, width of `wdata`; must be ≥ 8
- `COUNT_WIDTH`, 32, width of `cycle_count`
- `RESET_CYCLES`, 2, core reset hold after `rst` release; ≥ 1
- `MAX_CYCLES`, 16, run-cycle budget before timeout; ≥ 1
- `EXIT_ADDR`, 16'hFFFE, exit mailbox address
- `CONSOLE_ADDR`, 16'hFFFC, console mailbox address; ≠ `EXIT_ADDR`
- `CON_DEPTH`, 4, console FIFO entries; power of 2, ≥ 2

Ports:

- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `waddr` in `ADDR_WIDTH`: core data write address
- `wdata` in `DATA_WIDTH`: core data write data
- `we` in 1: core data write enable
- `cpu_rst` out 1: active-high reset to core and memories
- `cycle_count` out `COUNT_WIDTH`: RUN cycles elapsed
- `done` out 1: simulation finished, sticky
- `pass` out 1: finished via exit write of 0
- `timeout` out 1: finished via budget exhaustion
- `exit_code` out `DATA_WIDTH`: last exit mailbox value
- `con_valid` out 1: console byte available
- `con_data` out 8: console byte
- `con_ready` in 1: consumer accepts byte
- `con_overflow` out 1: sticky; a console byte was dropped

## Operation

- Asserting `rst` low immediately forces all state to reset values, regardless of current state.
- Reset values:
  - `cpu_rst` = 1
  - `done`, `pass`, `timeout`, `con_valid`, `con_overflow` = 0
  - `exit_code`, `cycle_count`, `con_data` = 0
  - FIFO empty, FSM = RESET
- `rst` release is synchronized with a 2-flop synchronizer before it affects the FSM.
- FSM states:
  - RESET: hold counter counts up to `RESET_CYCLES`, then go to RUN. `cpu_rst` = 1.
  - RUN: `cpu_rst` = 0; `cycle_count` increments every cycle.
  - DONE: `cpu_rst` = 1 to freeze the core; `cycle_count` holds. Left only by `rst`.
- Exit decode, RUN only: on `we && waddr == EXIT_ADDR`, load `exit_code` = `wdata` and set `done` = 1. Set `pass` = 1 when `wdata == 0`, otherwise `pass` = 0. Go to DONE.
- Timeout, RUN only: in the cycle where `cycle_count == MAX_CYCLES-1` with no exit write, set `done` = 1 and `timeout` = 1, leave `pass` = 0, go to DONE.
- An exit write in that same cycle takes priority: `timeout` stays 0.
- Console decode, RUN only: on `we && waddr == CONSOLE_ADDR`, push `wdata[7:0]`.
- Writes in RESET or DONE, and writes to any other address, are ignored.
- Console FIFO, `CON_DEPTH` entries:
  - Pop occurs on `con_valid && con_ready`.
  - A push while full is accepted only if a pop occurs in the same cycle. Otherwise the byte is dropped and `con_overflow` is set.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the occupancy unchanged.
  - Pointers wrap modulo `CON_DEPTH`.
  - The FIFO keeps draining in DONE.
- `cycle_count` saturates at all-ones and does not wrap.

## Timing

- `cpu_rst` falls on the (2 + `RESET_CYCLES`)th rising `clk` edge after `rst` rises. The 2 cycles are synchronizer latency.
- `cycle_count` is 0 in the first RUN cycle and N after N RUN edges.
- `done`, `pass`, `timeout` and `exit_code` are registered: they are visible the cycle after the decoding edge. `cpu_rst` rises on the same edge.
- Console latency is 1 cycle: `con_valid` asserts the cycle after the push edge into an empty FIFO.
- `con_data` is stable while `con_valid && !con_ready`.
- Throughput is 1 byte per cycle with `con_ready` held high.

## Configuration

- `SIM_MONITOR_TRACE_EN` defined:
  - Each accepted console pop is printed via `$write("%c")`.
  - On the first cycle `done` is high, a summary line is printed via `$display`: `cycle_count`, `pass`, `timeout`, `exit_code`.
  - `$finish` is called one cycle later.
- Undefined: no system tasks are present, and the block is fully synthesizable.
- Register-level behaviour is identical with and without the macro.

## Test plan

- Reset sequencing: release `rst` at cycle 0 with `RESET_CYCLES`=2 -> `cpu_rst` falls after edge 4; all outputs hold their reset values until then.
- Pass exit: write 16'h0000 to 16'hFFFE at `cycle_count`=5 -> next cycle `done`=1, `pass`=1, `exit_code`=0, `cpu_rst`=1, `cycle_count` frozen at 6.
- Fail exit versus timeout:
  - Write 16'h0003 to `EXIT_ADDR` in the same cycle `cycle_count`=15 (`MAX_CYCLES`=16) -> `done`=1, `pass`=0, `timeout`=0, `exit_code`=3.
  - Same run with no write -> `timeout`=1, `exit_code`=0.
- Console stream: push 'H','i' on back-to-back cycles with `con_ready`=1 -> `con_valid` high for 2 cycles carrying 8'h48 then 8'h69, starting 1 cycle after the first push.
- Console overflow: `CON_DEPTH`=4, `con_ready`=0, push 5 bytes -> first 4 are retained and `con_overflow`=1.
  - Then a 6th push while `con_ready`=1 and full -> accepted; the pop returns the first byte.
- Mid-run reset: pull `rst` low during RUN with 2 bytes queued -> all outputs return to reset values in the same cycle, and the FIFO is empty after release.
